// File: rtl/fl_netcope_remover_if.sv
// FrameLink bus bundle: data, byte remainder, active-low framing and handshake.
// The master drives the word; the slave drives dst_rdy_n back.
interface fl_netcope_remover_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned REM_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

    logic [DATA_WIDTH-1:0] data;
    logic [REM_WIDTH-1:0]  rem;
    logic                  sof_n;
    logic                  sop_n;
    logic                  eop_n;
    logic                  eof_n;
    logic                  src_rdy_n;
    logic                  dst_rdy_n;

    modport master (
        output data, rem, sof_n, sop_n, eop_n, eof_n, src_rdy_n,
        input  dst_rdy_n
    );

    modport slave (
        input  data, rem, sof_n, sop_n, eop_n, eof_n, src_rdy_n,
        output dst_rdy_n
    );
endinterface

// File: rtl/fl_netcope_remover.sv
// Strips the leading NetCOPE header part from FrameLink frames and forwards the payload
// as a new frame; captures the first header word and keeps wrap-around statistics.
module fl_netcope_remover #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    fl_netcope_remover_if.slave   rx,
    fl_netcope_remover_if.master  tx,
    output logic [DATA_WIDTH-1:0] hdr_data,
    output logic                  hdr_vld,
    output logic [CNT_WIDTH-1:0]  cnt_frames,
    output logic [CNT_WIDTH-1:0]  cnt_hdr_only,
    output logic [CNT_WIDTH-1:0]  cnt_orphan
);
    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StHdr      = 2'd1;
    localparam logic [1:0] StPayFirst = 2'd2;
    localparam logic [1:0] StPay      = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hdr_data_q;
    logic                  hdr_vld_q;
    logic [CNT_WIDTH-1:0]  cnt_frames_q, cnt_hdr_only_q, cnt_orphan_q;

    logic rx_dst_rdy_n;
    logic tx_src_rdy_n, tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n;
    logic rx_xfer;
    logic cap_hdr, inc_frames, inc_hdr_only, inc_orphan;

    // Header states swallow words unconditionally; payload states are a zero-latency wire.
    always_comb begin
        rx_dst_rdy_n = 1'b1;
        tx_src_rdy_n = 1'b1;
        tx_sof_n     = 1'b1;
        tx_sop_n     = 1'b1;
        tx_eop_n     = 1'b1;
        tx_eof_n     = 1'b1;
        if (!reset) begin
            case (state_q)
                StIdle, StHdr: rx_dst_rdy_n = 1'b0;
                StPayFirst, StPay: begin
                    rx_dst_rdy_n = tx.dst_rdy_n;
                    tx_src_rdy_n = rx.src_rdy_n;
                    tx_sof_n     = (state_q != StPayFirst);
                    tx_sop_n     = rx.sop_n;
                    tx_eop_n     = rx.eop_n;
                    tx_eof_n     = rx.eof_n;
                end
                default: ;
            endcase
        end
    end

    assign rx.dst_rdy_n = rx_dst_rdy_n;
    assign tx.data      = rx.data;
    assign tx.rem       = rx.rem;
    assign tx.src_rdy_n = tx_src_rdy_n;
    assign tx.sof_n     = tx_sof_n;
    assign tx.sop_n     = tx_sop_n;
    assign tx.eop_n     = tx_eop_n;
    assign tx.eof_n     = tx_eof_n;

    assign rx_xfer = !rx.src_rdy_n && !rx_dst_rdy_n;

    always_comb begin
        state_d      = state_q;
        cap_hdr      = 1'b0;
        inc_frames   = 1'b0;
        inc_hdr_only = 1'b0;
        inc_orphan   = 1'b0;
        if (rx_xfer) begin
            case (state_q)
                StIdle: begin
                    if (!rx.sof_n) begin
                        cap_hdr = 1'b1;
                        if (!rx.eof_n) begin
                            inc_hdr_only = 1'b1;
                        end else if (!rx.eop_n) begin
                            state_d = StPayFirst;
                        end else begin
                            state_d = StHdr;
                        end
                    end else begin
                        inc_orphan = 1'b1;
                    end
                end
                StHdr: begin
                    if (!rx.eof_n) begin
                        inc_hdr_only = 1'b1;
                        state_d      = StIdle;
                    end else if (!rx.eop_n) begin
                        state_d = StPayFirst;
                    end
                end
                StPayFirst, StPay: begin
                    if (!rx.eof_n) begin
                        inc_frames = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StPay;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            hdr_data_q     <= '0;
            hdr_vld_q      <= 1'b0;
            cnt_frames_q   <= '0;
            cnt_hdr_only_q <= '0;
            cnt_orphan_q   <= '0;
        end else begin
            state_q   <= state_d;
            hdr_vld_q <= cap_hdr;
            if (cap_hdr) begin
                hdr_data_q <= rx.data;
            end
            if (inc_frames) begin
                cnt_frames_q <= cnt_frames_q + CNT_WIDTH'(1);
            end
            if (inc_hdr_only) begin
                cnt_hdr_only_q <= cnt_hdr_only_q + CNT_WIDTH'(1);
            end
            if (inc_orphan) begin
                cnt_orphan_q <= cnt_orphan_q + CNT_WIDTH'(1);
            end
        end
    end

    assign hdr_data     = hdr_data_q;
    assign hdr_vld      = hdr_vld_q;
    assign cnt_frames   = cnt_frames_q;
    assign cnt_hdr_only = cnt_hdr_only_q;
    assign cnt_orphan   = cnt_orphan_q;
endmodule

// File: tb/tb_fl_netcope_remover.sv
// Bench for fl_netcope_remover: expected TX words are queued as payload is driven and
// popped by a monitor on every TX transfer.
module tb_fl_netcope_remover;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  rem;
        logic        sof_n;
        logic        sop_n;
        logic        eop_n;
        logic        eof_n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [DW-1:0] hdr_data;
    logic          hdr_vld;
    logic [CW-1:0] cnt_frames, cnt_hdr_only, cnt_orphan;

    int   tests   = 0;
    int   fails   = 0;
    int   vld_cnt = 0;
    bit   bp      = 1'b0;
    exp_t q[$];

    fl_netcope_remover_if #(.DATA_WIDTH(DW)) rx_if ();
    fl_netcope_remover_if #(.DATA_WIDTH(DW)) tx_if ();

    fl_netcope_remover #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx_if.slave),
        .tx          (tx_if.master),
        .hdr_data    (hdr_data),
        .hdr_vld     (hdr_vld),
        .cnt_frames  (cnt_frames),
        .cnt_hdr_only(cnt_hdr_only),
        .cnt_orphan  (cnt_orphan)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hdr_vld === 1'b1) vld_cnt++;
    end

    // TX monitor: every transfer must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e, got;
        #2;
        if (tx_if.src_rdy_n === 1'b0 && tx_if.dst_rdy_n === 1'b0) begin
            tests++;
            got = {tx_if.data, tx_if.rem, tx_if.sof_n, tx_if.sop_n, tx_if.eop_n, tx_if.eof_n};
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tx: got %h, required no transfer", got);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL tx_word: got %h, required %h", got, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        rx_if.src_rdy_n = 1'b1;
        rx_if.sof_n     = 1'b1;
        rx_if.sop_n     = 1'b1;
        rx_if.eop_n     = 1'b1;
        rx_if.eof_n     = 1'b1;
        tx_if.dst_rdy_n = bp ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_idle();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Hold one word until consumed; fwd marks payload words that must appear on TX.
    task automatic send(input logic [63:0] d, input logic [2:0] r, input logic sof_n,
                        input logic sop_n, input logic eop_n, input logic eof_n,
                        input bit fwd, input bit first);
        exp_t e;
        int   n = 0;
        logic want;
        if (fwd) begin
            e.data  = d;
            e.rem   = r;
            e.sof_n = !first;
            e.sop_n = sop_n;
            e.eop_n = eop_n;
            e.eof_n = eof_n;
            q.push_back(e);
        end
        forever begin
            @(negedge clk);
            rx_if.data      = d;
            rx_if.rem       = r;
            rx_if.sof_n     = sof_n;
            rx_if.sop_n     = sop_n;
            rx_if.eop_n     = eop_n;
            rx_if.eof_n     = eof_n;
            rx_if.src_rdy_n = 1'b0;
            tx_if.dst_rdy_n = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            want = fwd ? tx_if.dst_rdy_n : 1'b0;
            tests++;
            if (rx_if.dst_rdy_n !== want) begin
                fails++;
                $display("FAIL rx_dst_rdy_n: got %b, required %b", rx_if.dst_rdy_n, want);
            end
            if (rx_if.dst_rdy_n === 1'b0) break;
            n++;
            if (n >= 200) begin
                tests++;
                fails++;
                $display("FAIL word_timeout: word %h not consumed in 200 cycles", d);
                break;
            end
        end
    endtask

    task automatic send_frame(input int nh, input int np, input logic [63:0] base,
                              input logic [2:0] lrem);
        for (int i = 0; i < nh; i++) begin
            send(base + 64'(i), 3'd7, (i == 0) ? 1'b0 : 1'b1, (i == 0) ? 1'b0 : 1'b1,
                 (i == nh - 1) ? 1'b0 : 1'b1, (np == 0 && i == nh - 1) ? 1'b0 : 1'b1,
                 1'b0, 1'b0);
        end
        for (int j = 0; j < np; j++) begin
            send(base + 64'h100 + 64'(j), (j == np - 1) ? lrem : 3'd7, 1'b1,
                 (j == 0) ? 1'b0 : 1'b1, (j == np - 1) ? 1'b0 : 1'b1,
                 (j == np - 1) ? 1'b0 : 1'b1, 1'b1, j == 0);
        end
        idle(2);
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        rx_if.src_rdy_n = 1'b0;
        #1;
        tests++;
        if ({rx_if.dst_rdy_n, tx_if.src_rdy_n, tx_if.sof_n, tx_if.sop_n, tx_if.eop_n,
             tx_if.eof_n} !== 6'b111111) begin
            fails++;
            $display("FAIL reset_handshake: got %b%b%b%b%b%b, required 111111", rx_if.dst_rdy_n,
                     tx_if.src_rdy_n, tx_if.sof_n, tx_if.sop_n, tx_if.eop_n, tx_if.eof_n);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        #1;
        tests++;
        if (hdr_data !== '0 || hdr_vld !== 1'b0 || cnt_frames !== '0 || cnt_hdr_only !== '0 ||
            cnt_orphan !== '0) begin
            fails++;
            $display("FAIL reset_values: hdr=%h vld=%b frm=%0d ho=%0d orph=%0d, required all 0",
                     hdr_data, hdr_vld, cnt_frames, cnt_hdr_only, cnt_orphan);
        end
        tests++;
        if (rx_if.dst_rdy_n !== 1'b0 || tx_if.src_rdy_n !== 1'b1) begin
            fails++;
            $display("FAIL idle_handshake: rx_dst=%b tx_src=%b, required 0 1", rx_if.dst_rdy_n,
                     tx_if.src_rdy_n);
        end
    endtask

    task automatic test_basic();
        int v0 = vld_cnt;
        send_frame(2, 3, 64'h0123456789ABCDEF, 3'd5);
        tests++;
        if (hdr_data !== 64'h0123456789ABCDEF) begin
            fails++;
            $display("FAIL basic_hdr_data: got %h, required 0123456789abcdef", hdr_data);
        end
        tests++;
        if (vld_cnt - v0 != 1) begin
            fails++;
            $display("FAIL basic_hdr_vld: got %0d pulses, required 1", vld_cnt - v0);
        end
        tests++;
        if (cnt_frames !== 4'd1 || q.size() != 0) begin
            fails++;
            $display("FAIL basic_frames: cnt=%0d pending=%0d, required 1 0", cnt_frames, q.size());
        end
    endtask

    task automatic test_hdr_only();
        int v0 = vld_cnt;
        send_frame(1, 0, 64'hDEAD_BEEF_0000_0001, 3'd0);
        tests++;
        if (cnt_hdr_only !== 4'd1 || cnt_frames !== 4'd1) begin
            fails++;
            $display("FAIL hdr_only_cnt: ho=%0d frm=%0d, required 1 1", cnt_hdr_only, cnt_frames);
        end
        tests++;
        if (vld_cnt - v0 != 1 || hdr_data !== 64'hDEAD_BEEF_0000_0001) begin
            fails++;
            $display("FAIL hdr_only_vld: pulses=%0d hdr=%h, required 1 deadbeef00000001",
                     vld_cnt - v0, hdr_data);
        end
    endtask

    task automatic test_backpressure();
        bp = 1'b1;
        send(64'hAAAA_0000, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send(64'hAAAA_0001, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            // word 4 carries a stray SOF that must not leak through
            send(64'hBBBB_0000 + 64'(j), (j == 9) ? 3'd2 : 3'd7, (j == 4) ? 1'b0 : 1'b1,
                 (j == 0 || j == 4) ? 1'b0 : 1'b1, (j == 3 || j == 9) ? 1'b0 : 1'b1,
                 (j == 9) ? 1'b0 : 1'b1, 1'b1, j == 0);
        end
        bp = 1'b0;
        idle(2);
        tests++;
        if (cnt_frames !== 4'd2 || q.size() != 0) begin
            fails++;
            $display("FAIL bp_frames: cnt=%0d pending=%0d, required 2 0", cnt_frames, q.size());
        end
    endtask

    task automatic test_orphan();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(64'hCCCC_0000 + 64'(i), 3'd7, 1'b1, 1'b1, 1'b1, (i == 2) ? 1'b0 : 1'b1,
                 1'b0, 1'b0);
        end
        idle(1);
        send_frame(2, 3, 64'h5555_0000, 3'd3);
        tests++;
        if (cnt_orphan !== 4'd3 || cnt_frames !== 4'd1 || q.size() != 0) begin
            fails++;
            $display("FAIL orphan: orph=%0d frm=%0d pending=%0d, required 3 1 0", cnt_orphan,
                     cnt_frames, q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send(64'h7777_0000, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(64'h8888_0000, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        rx_if.data  = 64'h8888_0001;
        rx_if.sop_n = 1'b1;
        rx_if.src_rdy_n = 1'b0;
        #1;
        tests++;
        if (rx_if.dst_rdy_n !== 1'b1 || tx_if.src_rdy_n !== 1'b1) begin
            fails++;
            $display("FAIL midreset_handshake: rx_dst=%b tx_src=%b, required 1 1",
                     rx_if.dst_rdy_n, tx_if.src_rdy_n);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        for (int j = 2; j < 6; j++) begin
            send(64'h8888_0000 + 64'(j), 3'd7, 1'b1, 1'b1, (j == 5) ? 1'b0 : 1'b1,
                 (j == 5) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        end
        idle(1);
        tests++;
        if (cnt_orphan !== 4'd4 || cnt_frames !== 4'd0 || q.size() != 0) begin
            fails++;
            $display("FAIL midreset_discard: orph=%0d frm=%0d pending=%0d, required 4 0 0",
                     cnt_orphan, cnt_frames, q.size());
        end
        send_frame(1, 2, 64'h9999_0000, 3'd1);
        tests++;
        if (cnt_frames !== 4'd1 || cnt_orphan !== 4'd4 || q.size() != 0) begin
            fails++;
            $display("FAIL midreset_new_frame: frm=%0d orph=%0d pending=%0d, required 1 4 0",
                     cnt_frames, cnt_orphan, q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_frame(1, 1, 64'h1000 * 64'(i), 3'd4);
            if (i == 14) begin
                tests++;
                if (cnt_frames !== 4'd15) begin
                    fails++;
                    $display("FAIL wrap_pre: got %0d, required 15", cnt_frames);
                end
            end
        end
        tests++;
        if (cnt_frames !== 4'd0 || q.size() != 0) begin
            fails++;
            $display("FAIL wrap: cnt=%0d pending=%0d, required 0 0", cnt_frames, q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_if.data = '0;
        rx_if.rem  = '0;
        drive_idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_hdr_only();
        test_backpressure();
        test_orphan();
        test_reset_mid_frame();
        test_wrap();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fl_netcope_remover.md
Name: fl_netcope_remover

Overview:
- Receive-side counterpart of the NetCOPE header adder in the fl_tools/edit family.
- Takes FrameLink frames whose first part is the NetCOPE header that the adder inserted, and strips that part.
- Forwards the remaining parts as a new frame, with SOF re-marked on the first payload word.
- Captures the first header word (timestamp) and keeps statistics counters; sits between the RX FrameLink pipeline and the user application.

Parameters:
DATA_WIDTH, 64, FrameLink data width in bits; must be 8, 16, 32, 64 or 128.
CNT_WIDTH, 32, width of the statistics counters.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
RX_DATA  in  DATA_WIDTH  input data word
RX_REM  in  log2(DATA_WIDTH/8)  index of the last valid byte in the word
RX_SOF_N  in  1  start of frame, active low
RX_SOP_N  in  1  start of part, active low
RX_EOP_N  in  1  end of part, active low
RX_EOF_N  in  1  end of frame, active low
RX_SRC_RDY_N  in  1  input word valid, active low
RX_DST_RDY_N  out  1  block ready, active low
TX_DATA  out  DATA_WIDTH  output data word
TX_REM  out  log2(DATA_WIDTH/8)  last valid byte index
TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N  out  1 each  output framing, active low
TX_SRC_RDY_N  out  1  output word valid, active low
TX_DST_RDY_N  in  1  downstream ready, active low
HDR_DATA  out  DATA_WIDTH  first word of the last received header
HDR_VLD  out  1  one-cycle pulse when HDR_DATA updates
CNT_FRAMES  out  CNT_WIDTH  frames forwarded with a payload
CNT_HDR_ONLY  out  CNT_WIDTH  frames consisting only of a header part (dropped)
CNT_ORPHAN  out  CNT_WIDTH  words discarded because no SOF was seen

Behaviour:
- Transfer rules:
  - RX transfer = RX_SRC_RDY_N=0 and RX_DST_RDY_N=0.
  - TX transfer = TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
- FSM states: IDLE, HDR, PAY_FIRST, PAY. Reset value is IDLE.
- IDLE:
  - RX_DST_RDY_N=0 and TX_SRC_RDY_N=1; every word is consumed.
  - Transfer with SOF_N=0: HDR_DATA<=RX_DATA and HDR_VLD=1 on the next cycle.
    - If EOF_N=0: increment CNT_HDR_ONLY, stay in IDLE.
    - Else if EOP_N=0: go to PAY_FIRST.
    - Else: go to HDR.
  - Transfer with SOF_N=1: increment CNT_ORPHAN, stay in IDLE.
- HDR:
  - RX_DST_RDY_N=0 and TX_SRC_RDY_N=1; header words are consumed and dropped.
  - Transfer with EOF_N=0: increment CNT_HDR_ONLY, go to IDLE.
  - Transfer with EOP_N=0: go to PAY_FIRST.
- PAY_FIRST and PAY are combinational pass-through:
  - TX_DATA/REM/SOP_N/EOP_N/EOF_N = RX values.
  - TX_SRC_RDY_N = RX_SRC_RDY_N.
  - RX_DST_RDY_N = TX_DST_RDY_N.
  - TX_SOF_N=0 in PAY_FIRST, 1 in PAY (the RX SOF_N value is ignored).
  - PAY_FIRST --transfer--> PAY, or IDLE if EOF_N=0 (counted in CNT_FRAMES).
  - PAY --transfer with EOF_N=0--> IDLE, increment CNT_FRAMES.
- Latency: 0 cycles on payload words; header words produce no TX activity.
- Protocol faults in PAY_FIRST/PAY:
  - RX SOF_N=0 mid-frame: the word is forwarded with TX_SOF_N forced as above; no recovery action.
- Counters:
  - Wrap modulo 2^CNT_WIDTH.
  - Reset to 0.
  - Never saturate.
- Reset values, applied on any cycle including mid-frame:
  - state IDLE; RX_DST_RDY_N=1 during the reset cycle.
  - TX_SRC_RDY_N=1, TX_*OF_N/*OP_N=1.
  - HDR_DATA=0, HDR_VLD=0, all counters 0.
  - After reset, the rest of an interrupted frame is discarded word by word into CNT_ORPHAN until the next SOF.
- TX_DATA/TX_REM are don't-care while TX_SRC_RDY_N=1.

Test Plan:
- 64-bit frame: header part of 2 words (first word 0x0123456789ABCDEF), payload part of 3 words, REM=5 on the last -> TX emits exactly 3 words, SOF_N=0 on word 1, EOF_N=0 with REM=5 on word 3; HDR_DATA=0x0123456789ABCDEF with one HDR_VLD pulse; CNT_FRAMES=1.
- Single-word header with SOF=EOP=EOF all low -> no TX activity; CNT_HDR_ONLY=1; HDR_VLD pulses once.
- TX_DST_RDY_N toggled randomly 50% during a 2-part, 10-word payload -> no loss or duplication; RX_DST_RDY_N mirrors TX_DST_RDY_N in PAY; header words are consumed regardless of TX_DST_RDY_N.
- 3 words without SOF, then a valid frame -> CNT_ORPHAN=3; the frame is forwarded intact.
- RESET asserted for 1 cycle in the 2nd payload word of a 6-word payload, followed by the remaining 4 words and then a new frame -> the 4 words are discarded (CNT_ORPHAN=4); the new frame is forwarded; counters restart from 0.
- 2^CNT_WIDTH frames with CNT_WIDTH=4 -> CNT_FRAMES wraps to 0 after 16 frames.
